// File: rtl/rojo_pkg.sv
// Shared types and constants for the Rojobot update responder.
package rojo_pkg;
  localparam int FIELD_W = 8;
  localparam int SNAP_W  = 4 * FIELD_W;

  localparam logic [7:0] MOTCTL_STOP = 8'h00;
  localparam logic [7:0] OVR_MAX     = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [FIELD_W-1:0] locx;
    logic [FIELD_W-1:0] locy;
    logic [FIELD_W-1:0] sensors;
    logic [FIELD_W-1:0] botinfo;
  } snap_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == OVR_MAX) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/rojo_sync_edge.sv
// Multi-flop synchronizer for the bot's update strobe plus a registered rising-edge detect.
module rojo_sync_edge
  import rojo_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic                   r_rise;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_dly  <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_dly;
    end
  end

  assign o_rise = r_rise;
endmodule

// File: rtl/rojo_upd_responder.sv
// Core-side responder for the Rojobot update handshake: snapshot, level IRQ, MotCtl register.
// Optional MotCtl watchdog enabled by defining ROJO_MOTCTL_WDT_EN.
module rojo_upd_responder
  import rojo_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int WDT_LIMIT   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_upd,
  input  logic [FIELD_W-1:0] i_locx,
  input  logic [FIELD_W-1:0] i_locy,
  input  logic [FIELD_W-1:0] i_sensors,
  input  logic [FIELD_W-1:0] i_botinfo,
  input  logic               i_ack,
  input  logic               i_motctl_wr,
  input  logic [7:0]         i_motctl_wdata,
  output logic               o_irq,
  output logic [SNAP_W-1:0]  o_snap,
  output logic [CNT_W-1:0]   o_upd_cnt,
  output logic [7:0]         o_ovr_cnt,
  output logic [7:0]         o_motctl,
  output logic               o_wdt_trip
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  if (WDT_LIMIT < 1 || WDT_LIMIT > 255) begin : g_bad_wdt
    $error("WDT_LIMIT must be 1..255");
  end

  logic             w_upd_rise;
  state_t           r_state;
  logic             r_pend_next;
  logic [7:0]       r_ovr_cnt;
  snap_t            r_snap;
  logic [CNT_W-1:0] r_upd_cnt;
  logic [7:0]       r_motctl;

  rojo_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_async(i_upd),
    .o_rise (w_upd_rise)
  );

  // Bot registers are long-stable after the strobe, so they are sampled directly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_snap    <= '0;
      r_upd_cnt <= '0;
    end else if (w_upd_rise) begin
      r_snap    <= {i_locx, i_locy, i_sensors, i_botinfo};
      r_upd_cnt <= r_upd_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_pend_next <= 1'b0;
      r_ovr_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_upd_rise) r_state <= S_PEND;
        end
        S_PEND: begin
          if (i_ack) begin
            r_state     <= S_HOLD;
            r_pend_next <= w_upd_rise;
          end else if (w_upd_rise) begin
            r_ovr_cnt <= sat_inc8(r_ovr_cnt);
          end
        end
        S_HOLD: begin
          if (w_upd_rise && r_pend_next) r_ovr_cnt <= sat_inc8(r_ovr_cnt);
          // An update landing on the release edge still counts as pending.
          if (!i_ack) begin
            r_state     <= (r_pend_next || w_upd_rise) ? S_PEND : S_IDLE;
            r_pend_next <= 1'b0;
          end else if (w_upd_rise) begin
            r_pend_next <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ROJO_MOTCTL_WDT_EN
  logic [7:0] r_wdt_cnt;
  logic       r_wdt_trip;

  // A write on the tripping edge wins: it reloads MotCtl and restarts the count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_motctl   <= '0;
      r_wdt_cnt  <= '0;
      r_wdt_trip <= 1'b0;
    end else if (i_motctl_wr) begin
      r_motctl   <= i_motctl_wdata;
      r_wdt_cnt  <= '0;
      r_wdt_trip <= 1'b0;
    end else if (w_upd_rise && (r_wdt_cnt != 8'(WDT_LIMIT))) begin
      r_wdt_cnt <= r_wdt_cnt + 8'd1;
      if ((r_wdt_cnt + 8'd1) == 8'(WDT_LIMIT)) begin
        r_motctl   <= MOTCTL_STOP;
        r_wdt_trip <= 1'b1;
      end
    end
  end

  assign o_wdt_trip = r_wdt_trip;
`else
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_motctl <= '0;
    end else if (i_motctl_wr) begin
      r_motctl <= i_motctl_wdata;
    end
  end

  assign o_wdt_trip = 1'b0;
`endif

  assign o_irq     = (r_state == S_PEND);
  assign o_snap    = r_snap;
  assign o_upd_cnt = r_upd_cnt;
  assign o_ovr_cnt = r_ovr_cnt;
  assign o_motctl  = r_motctl;
endmodule

// File: tb/tb_rojo_upd_responder.sv
// Self-checking bench for rojo_upd_responder: handshake table, directed corners, random vs. event model.
module tb_rojo_upd_responder;
  localparam int SYNC = 3;
  localparam int CW   = 4;
  localparam int WL   = 8;
  localparam int A    = SYNC + 4;
  localparam int NT   = A + 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       d_rst = 1'b0, d_upd = 1'b0, d_ack = 1'b0, d_wr = 1'b0;
  logic [7:0] d_wd = '0, d_lx = '0, d_ly = '0, d_se = '0, d_bi = '0;

  logic          o_irq, o_wdt_trip;
  logic [31:0]   o_snap;
  logic [CW-1:0] o_upd_cnt;
  logic [7:0]    o_ovr_cnt, o_motctl;

  rojo_upd_responder #(
    .SYNC_STAGES(SYNC),
    .CNT_W      (CW),
    .WDT_LIMIT  (WL)
  ) dut (
    .i_clk         (clk),
    .i_rst         (d_rst),
    .i_upd         (d_upd),
    .i_locx        (d_lx),
    .i_locy        (d_ly),
    .i_sensors     (d_se),
    .i_botinfo     (d_bi),
    .i_ack         (d_ack),
    .i_motctl_wr   (d_wr),
    .i_motctl_wdata(d_wd),
    .o_irq         (o_irq),
    .o_snap        (o_snap),
    .o_upd_cnt     (o_upd_cnt),
    .o_ovr_cnt     (o_ovr_cnt),
    .o_motctl      (o_motctl),
    .o_wdt_trip    (o_wdt_trip)
  );

  int n_vec = 0;
  int n_err = 0;
  bit verbose = 1'b1;

  // Event-level reference: an update "arrives" SYNC+1 edges after i_upd is first seen high.
  int          m_hist[$];
  bit          m_irq, m_held, m_queued, m_trip;
  logic [31:0] m_snap;
  int          m_cnt, m_ovr, m_mot, m_wc;

  function automatic void model_reset();
    m_hist.delete();
    for (int i = 0; i < SYNC + 2; i++) m_hist.push_back(0);
    m_irq = 0; m_held = 0; m_queued = 0; m_trip = 0;
    m_snap = '0; m_cnt = 0; m_ovr = 0; m_mot = 0; m_wc = 0;
  endfunction

  function automatic void model_edge();
    bit arrive;
    int n;
    if (d_rst) begin
      model_reset();
      return;
    end
    m_hist.push_back(int'(d_upd));
    if (m_hist.size() > 16) void'(m_hist.pop_front());
    n = m_hist.size();
    arrive = (m_hist[n-SYNC-2] == 1) && (m_hist[n-SYNC-3] == 0);
    if (arrive) begin
      m_snap = {d_lx, d_ly, d_se, d_bi};
      m_cnt  = (m_cnt + 1) % (1 << CW);
    end
    if (m_irq) begin
      if (d_ack) begin
        m_irq = 0; m_held = 1; m_queued = arrive;
      end else if (arrive && m_ovr < 255) begin
        m_ovr++;
      end
    end else if (m_held) begin
      if (arrive && m_queued && m_ovr < 255) m_ovr++;
      if (!d_ack) begin
        m_held = 0;
        m_irq = m_queued || arrive;
        m_queued = 0;
      end else if (arrive) begin
        m_queued = 1;
      end
    end else if (arrive) begin
      m_irq = 1;
    end
`ifdef ROJO_MOTCTL_WDT_EN
    if (d_wr) begin
      m_mot = int'(d_wd); m_wc = 0; m_trip = 0;
    end else if (arrive && m_wc < WL) begin
      m_wc++;
      if (m_wc == WL) begin
        m_mot = 0; m_trip = 1;
      end
    end
`else
    if (d_wr) m_mot = int'(d_wd);
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("m_irq",  32'(o_irq),      32'(m_irq));
    chk("m_snap", o_snap,          m_snap);
    chk("m_cnt",  32'(o_upd_cnt),  32'(m_cnt));
    chk("m_ovr",  32'(o_ovr_cnt),  32'(m_ovr));
    chk("m_mot",  32'(o_motctl),   32'(m_mot));
    chk("m_trip", 32'(o_wdt_trip), 32'(m_trip));
  endtask

  // One update transaction: pulse, then wait until the capture edge has passed.
  task automatic upd_txn(input logic [7:0] lx, ly, se, bi);
    d_lx = lx; d_ly = ly; d_se = se; d_bi = bi;
    d_upd = 1'b1; tick();
    d_upd = 1'b0; tick();
    repeat (SYNC) tick();
    if (verbose)
      $display("upd snap=%h cnt=%0d ovr=%0d irq=%0b mot=%h trip=%0b",
               o_snap, o_upd_cnt, o_ovr_cnt, o_irq, o_motctl, o_wdt_trip);
  endtask

  typedef struct {
    logic          upd;
    logic          ack;
    logic          exp_irq;
    logic [CW-1:0] exp_cnt;
    logic [31:0]   exp_snap;
  } vec_t;

  vec_t tbl[NT];

  initial begin
    for (int i = 0; i < NT; i++) begin
      tbl[i].upd      = (i <= SYNC + 1);
      tbl[i].ack      = (i >= A) && (i < A + 5);
      tbl[i].exp_irq  = (i >= SYNC + 1) && (i < A);
      tbl[i].exp_cnt  = (i >= SYNC + 1) ? CW'(1) : CW'(0);
      tbl[i].exp_snap = (i >= SYNC + 1) ? 32'h12345678 : 32'h0;
    end
    model_reset();

    // Reset state
    d_rst = 1'b1; tick(); d_rst = 1'b0;
    tick(); tick();
    chk("rst_irq", 32'(o_irq), 32'd0);
    chk("rst_snap", o_snap, 32'd0);
    chk("rst_cnt", 32'(o_upd_cnt), 32'd0);
    chk("rst_mot", 32'(o_motctl), 32'd0);

    // Latency and basic ack handshake
    d_lx = 8'h12; d_ly = 8'h34; d_se = 8'h56; d_bi = 8'h78;
    for (int i = 0; i < NT; i++) begin
      d_upd = tbl[i].upd;
      d_ack = tbl[i].ack;
      tick();
      chk($sformatf("tbl%0d_irq", i), 32'(o_irq), 32'(tbl[i].exp_irq));
      chk($sformatf("tbl%0d_cnt", i), 32'(o_upd_cnt), 32'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_snap", i), o_snap, tbl[i].exp_snap);
      $display("vec %0d upd=%0b ack=%0b irq=%0b cnt=%0d", i, d_upd, d_ack, o_irq, o_upd_cnt);
    end
    chk("tbl_ovr", 32'(o_ovr_cnt), 32'd0);

    // Overrun with no ack
    upd_txn(8'h11, 8'h22, 8'h33, 8'h44);
    chk("ovr_first_irq", 32'(o_irq), 32'd1);
    upd_txn(8'hAA, 8'h22, 8'h33, 8'h44);
    chk("ovr_locx", 32'(o_snap[31:24]), 32'hAA);
    chk("ovr_cnt1", 32'(o_ovr_cnt), 32'd1);
    chk("ovr_irq", 32'(o_irq), 32'd1);

    // Update while held, then release
    d_ack = 1'b1; tick();
    chk("ack_drop", 32'(o_irq), 32'd0);
    upd_txn(8'h5A, 8'h01, 8'h02, 8'h03);
    chk("hold_noovr", 32'(o_ovr_cnt), 32'd1);
    chk("hold_irq0", 32'(o_irq), 32'd0);
    d_ack = 1'b0; tick();
    chk("rearm_irq", 32'(o_irq), 32'd1);
    chk("rearm_ovr", 32'(o_ovr_cnt), 32'd1);
    d_ack = 1'b1; tick();
    upd_txn(8'h61, 8'h00, 8'h00, 8'h00);
    upd_txn(8'h62, 8'h00, 8'h00, 8'h00);
    chk("hold_ovr2", 32'(o_ovr_cnt), 32'd2);
    d_ack = 1'b0; tick();
    chk("rearm2_irq", 32'(o_irq), 32'd1);
    d_ack = 1'b1; tick(); d_ack = 1'b0; tick();
    chk("idle_irq", 32'(o_irq), 32'd0);

    // MotCtl and watchdog
    d_wr = 1'b1; d_wd = 8'h33; tick(); d_wr = 1'b0;
    chk("mot_33", 32'(o_motctl), 32'h33);
    repeat (WL) upd_txn(8'h01, 8'h02, 8'h03, 8'h04);
`ifdef ROJO_MOTCTL_WDT_EN
    chk("wdt_mot", 32'(o_motctl), 32'h00);
    chk("wdt_trip", 32'(o_wdt_trip), 32'd1);
`else
    chk("wdt_mot", 32'(o_motctl), 32'h33);
    chk("wdt_trip", 32'(o_wdt_trip), 32'd0);
`endif
    d_wr = 1'b1; d_wd = 8'h44; tick(); d_wr = 1'b0;
    chk("mot_44", 32'(o_motctl), 32'h44);
    chk("trip_clr", 32'(o_wdt_trip), 32'd0);
    repeat (WL - 1) upd_txn(8'h09, 8'h08, 8'h07, 8'h06);
    // Write lands on the would-be tripping capture edge
    d_upd = 1'b1; tick(); d_upd = 1'b0; tick();
    repeat (SYNC - 1) tick();
    d_wr = 1'b1; d_wd = 8'h55; tick(); d_wr = 1'b0;
    chk("race_mot", 32'(o_motctl), 32'h55);
    chk("race_trip", 32'(o_wdt_trip), 32'd0);
    upd_txn(8'h09, 8'h08, 8'h07, 8'h06);
    chk("race_after", 32'(o_wdt_trip), 32'd0);

    // Reset while pending, then counter wrap
    upd_txn(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    chk("pre_rst_irq", 32'(o_irq), 32'd1);
    d_rst = 1'b1; tick(); d_rst = 1'b0;
    chk("mid_rst_irq", 32'(o_irq), 32'd0);
    chk("mid_rst_snap", o_snap, 32'd0);
    chk("mid_rst_cnt", 32'(o_upd_cnt), 32'd0);
    chk("mid_rst_ovr", 32'(o_ovr_cnt), 32'd0);
    chk("mid_rst_mot", 32'(o_motctl), 32'd0);
    chk("mid_rst_trip", 32'(o_wdt_trip), 32'd0);
    repeat ((1 << CW) + 1) upd_txn(8'h10, 8'h20, 8'h30, 8'h40);
    chk("cnt_wrap", 32'(o_upd_cnt), 32'd1);

    // Randomized traffic against the model
    verbose = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      d_upd = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) d_ack = ~d_ack;
      d_wr  = ($urandom_range(0, 39) == 0);
      d_wd  = 8'($urandom);
      d_lx  = 8'($urandom); d_ly = 8'($urandom);
      d_se  = 8'($urandom); d_bi = 8'($urandom);
      d_rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    d_rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rojo_upd_responder.md
Name: rojo_upd_responder

Overview:
- CPU-clock-side responder for the Rojobot system-register update handshake.
- Synchronizes the bot's update pulse and captures an atomic 32-bit snapshot of LocX/LocY/Sensors/BotInfo.
- Raises a level interrupt and holds it until firmware acknowledges through a level ack bit driven from GPIO.
- Also owns the MotCtl register the CPU writes to steer the bot; sits between rojobot31_0 outputs and swervolf_core I/O in the clk_core domain.

Parameters:
- SYNC_STAGES, 2, number of flops synchronizing i_upd into i_clk (legal 2..4).
- CNT_W, 16, width of the wrapping update counter o_upd_cnt.
- WDT_LIMIT, 8, number of updates without a MotCtl write before the watchdog trips (used only with the optional feature; legal 1..255).

Ports:
- i_clk  in  1  core clock (clk_core).
- i_rst  in  1  synchronous, active-high reset.
- i_upd  in  1  upd_sysregs from the bot, in a foreign clock domain; only its rising edge is used.
- i_locx  in  8  bot X location.
- i_locy  in  8  bot Y location.
- i_sensors  in  8  bot sensor register.
- i_botinfo  in  8  bot info register.
- i_ack  in  1  level acknowledge from firmware (GPIO bit).
- i_motctl_wr  in  1  one-cycle MotCtl write strobe.
- i_motctl_wdata  in  8  MotCtl write data.
- o_irq  out  1  update-pending interrupt, level.
- o_snap  out  32  {locx, locy, sensors, botinfo} captured on the last update.
- o_upd_cnt  out  CNT_W  count of detected updates.
- o_ovr_cnt  out  8  count of updates that overwrote an unacknowledged snapshot.
- o_motctl  out  8  MotCtl value driven to the bot.
- o_wdt_trip  out  1  watchdog tripped (optional feature).

Behaviour:
- Reset (i_rst high at a clock edge) clears, on that edge:
  - all outputs to 0;
  - synchronizer flops to 0;
  - FSM to S_IDLE;
  - pending_next to 0;
  - watchdog counter to 0.
- Reset mid-handshake discards any pending update and drops o_irq the next cycle.
- Update detect:
  - i_upd passes through SYNC_STAGES flops; upd_rise = last stage high AND a delayed copy of it low.
  - A rising i_upd sampled at edge 0 produces upd_rise after SYNC_STAGES+1 edges.
  - The capture and o_irq appear one edge after upd_rise.
  - Bot registers are stable for many cycles after upd_sysregs, so capturing them directly is safe; no data synchronizer is used.
- Every upd_rise:
  - o_snap <= {i_locx, i_locy, i_sensors, i_botinfo};
  - o_upd_cnt <= o_upd_cnt + 1, wrapping at 2^CNT_W.
- FSM:
  - S_IDLE: o_irq=0. On upd_rise go to S_PEND with o_irq=1.
  - S_PEND: o_irq=1.
    - i_ack=1: go to S_HOLD with o_irq=0.
    - upd_rise with i_ack=0: recapture (newest wins), o_ovr_cnt++ saturating at 255, stay in S_PEND.
    - upd_rise with i_ack=1 on the same edge: go to S_HOLD and set pending_next=1; no overrun is counted.
  - S_HOLD: o_irq=0, waiting for firmware to release ack.
    - upd_rise: capture; if pending_next was already 1, o_ovr_cnt++; then set pending_next=1.
    - i_ack=0: if pending_next is 1, go to S_PEND with o_irq=1 and clear pending_next; otherwise go to S_IDLE.
  - i_ack high in S_IDLE is ignored.
- MotCtl: i_motctl_wr=1 at an edge makes o_motctl = i_motctl_wdata after that edge; there is no read-back path.

Optional Feature:
- Macro ROJO_MOTCTL_WDT_EN.
- Defined:
  - An 8-bit counter increments on each upd_rise and clears on i_motctl_wr.
  - When the counter reaches WDT_LIMIT, o_motctl <= 8'h00 (stop) and o_wdt_trip <= 1; the counter holds.
  - A following i_motctl_wr clears o_wdt_trip and loads the new value.
  - i_motctl_wr and the tripping upd_rise on the same edge: the write wins, the counter clears and there is no trip.
- Undefined: no counter exists, o_wdt_trip is tied 0, and MotCtl is held indefinitely.

Decomposition:
- Package rojo_pkg holds:
  - state enum (S_IDLE, S_PEND, S_HOLD), 2 bits;
  - snapshot packed struct {locx, locy, sensors, botinfo};
  - localparam MOTCTL_STOP = 8'h00;
  - field width constants.
- One sub-module, rojo_sync_edge: SYNC_STAGES synchronizer plus rising-edge detect, output upd_rise.

Test Plan:
- Reset then i_upd pulse with locx=8'h12, locy=8'h34, sensors=8'h56, botinfo=8'h78 -> o_snap=32'h12345678, o_irq=1 exactly SYNC_STAGES+2 edges after i_upd rises, o_upd_cnt=1.
- Assert i_ack while in S_PEND, hold it 5 cycles, then release -> o_irq drops one edge after ack, FSM returns to S_IDLE, no re-assert.
- Two updates with no ack (second locx=8'hAA) -> o_snap[31:24]=8'hAA, o_ovr_cnt=1, o_irq stays 1.
- Update during S_HOLD, then release ack -> o_irq re-asserts one edge after ack falls, o_ovr_cnt unchanged; a third update while still held -> o_ovr_cnt increments.
- Write MotCtl=8'h33, then WDT_LIMIT=8 updates with no write (ROJO_MOTCTL_WDT_EN defined) -> o_motctl=8'h00, o_wdt_trip=1; write 8'h44 -> o_motctl=8'h44, trip cleared. Repeat with the macro undefined -> o_motctl stays 8'h33.
- Assert i_rst while in S_PEND; also run 2^CNT_W+1 updates -> after reset all outputs are 0; o_upd_cnt wraps to 1.
